// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: three byte reads per 24-bit big-endian instruction,
// valid/ready hand-off to decode, branch redirect, halt and out-of-range fault.
module instr_fetch_seq #(
  parameter int                ADDR_W    = 24,
  parameter int                MEM_DEPTH = 128,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [23:0]       instruction,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              busy,
  output logic              fetch_error
);

  typedef enum logic [2:0] {
    S_F0    = 3'd0,
    S_F1    = 3'd1,
    S_F2    = 3'd2,
    S_F3    = 3'd3,
    S_VALID = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        byte0, byte1;
  logic [ADDR_W:0]   pc_end;
  logic              out_of_range;
  logic              handshake;

  logic              mem_read_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              busy_d;
  logic              instr_valid_d;
  logic              fetch_error_d;

  // The extra carry bit turns a wrap past the top of the address space into a fault.
  assign pc_end       = {1'b0, pc} + (ADDR_W+1)'(2);
  assign out_of_range = ({1'b0, pc} >= DEPTH) || (pc_end >= DEPTH);
  assign handshake    = (state == S_VALID) && instr_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_F0;
      mem_read    <= 1'b0;
      mem_addr    <= '0;
      busy        <= 1'b0;
      instr_valid <= 1'b0;
      fetch_error <= 1'b0;
    end else begin
      state       <= state_nxt;
      mem_read    <= mem_read_d;
      mem_addr    <= mem_addr_d;
      busy        <= busy_d;
      instr_valid <= instr_valid_d;
      fetch_error <= fetch_error_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = S_F0;
    end else begin
      case (state)
        S_F0:    if (!halt) state_nxt = out_of_range ? S_FAULT : S_F1;
        S_F1:    state_nxt = S_F2;
        S_F2:    state_nxt = S_F3;
        S_F3:    state_nxt = S_VALID;
        S_VALID: if (instr_ready) state_nxt = S_F0;
        S_FAULT: state_nxt = S_FAULT;
        default: state_nxt = S_F0;
      endcase
    end
  end

  // Registered outputs are a function of the state being entered.
  always_comb begin
    mem_read_d    = 1'b0;
    mem_addr_d    = mem_addr;
    busy_d        = 1'b0;
    instr_valid_d = 1'b0;
    fetch_error_d = 1'b0;
    case (state_nxt)
      S_F1: begin
        mem_read_d = 1'b1;
        mem_addr_d = pc;
        busy_d     = 1'b1;
      end
      S_F2: begin
        mem_read_d = 1'b1;
        mem_addr_d = pc + ADDR_W'(1);
        busy_d     = 1'b1;
      end
      S_F3: begin
        mem_read_d = 1'b1;
        mem_addr_d = pc + ADDR_W'(2);
        busy_d     = 1'b1;
      end
      S_VALID: instr_valid_d = 1'b1;
      S_FAULT: fetch_error_d = 1'b1;
      default: ;
    endcase
  end

  // Datapath: PC, partial bytes and the presented instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      byte0       <= '0;
      byte1       <= '0;
      instruction <= '0;
      instr_pc    <= '0;
    end else begin
      if (redirect) begin
        pc <= redirect_pc;
      end else begin
        if (handshake) pc <= pc + ADDR_W'(3);
        case (state)
          S_F1: byte0 <= mem_data;
          S_F2: byte1 <= mem_data;
          S_F3: begin
            instruction <= {byte0, byte1, mem_data};
            instr_pc    <= pc;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq: scoreboarded byte addresses and
// instruction hand-offs, plus per-scenario inline checks.
module tb_instr_fetch_seq;

  localparam int ADDR_W = 24;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic [23:0]       instruction;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              busy;
  logic              fetch_error;

  logic [7:0] mem [256];

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [23:0]       instr;
  } exp_t;

  exp_t              iq[$];
  logic [ADDR_W-1:0] aq[$];
  int                total  = 0;
  int                passed = 0;

  instr_fetch_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .instruction(instruction),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt),
    .busy       (busy),
    .fetch_error(fetch_error)
  );

  always #5 clk = ~clk;

  // Memory answers during the cycle its read strobe is high.
  assign mem_data = mem_read ? mem[mem_addr[7:0]] : 8'h00;

  always @(negedge clk) begin : mon_addr
    logic [ADDR_W-1:0] a;
    if (rst_n === 1'b1 && mem_read === 1'b1) begin
      total++;
      if (aq.size() == 0) begin
        $display("FAIL mem_addr: unexpected read of %h, none expected", mem_addr);
      end else begin
        a = aq.pop_front();
        if (mem_addr !== a) $display("FAIL mem_addr: got %h expected %h", mem_addr, a);
        else passed++;
      end
    end
  end

  always @(negedge clk) begin : mon_instr
    exp_t e;
    if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      total++;
      if (iq.size() == 0) begin
        $display("FAIL handoff: unexpected instr %h @%h, none expected", instruction, instr_pc);
      end else begin
        e = iq.pop_front();
        if ({instr_pc, instruction} !== {e.pc, e.instr})
          $display("FAIL handoff: got %h @%h expected %h @%h", instruction, instr_pc, e.instr, e.pc);
        else passed++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input logic [ADDR_W-1:0] pc);
    exp_t       e;
    logic [7:0] a;
    a = pc[7:0];
    for (int k = 0; k < 3; k++) aq.push_back(pc + ADDR_W'(k));
    e.pc    = pc;
    e.instr = {mem[a], mem[a + 8'd1], mem[a + 8'd2]};
    iq.push_back(e);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n = 0;
    while (instr_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (instr_valid !== 1'b1) begin
      total++;
      $display("FAIL %s: instr_valid not seen within %0d cycles", tag, budget);
    end
  endtask

  task automatic test_reset();
    logic saw = 1'b0;
    #1;
    total++;
    if ({mem_read, mem_addr, instruction, instr_pc, instr_valid, busy, fetch_error} !== '0)
      $display("FAIL reset_values: got rd=%b addr=%h ins=%h ipc=%h v=%b busy=%b err=%b expected all 0",
               mem_read, mem_addr, instruction, instr_pc, instr_valid, busy, fetch_error);
    else passed++;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      saw |= (mem_read | busy);
    end
    total++;
    if (saw !== 1'b0) $display("FAIL halt_at_reset: read/busy seen=%b expected 0", saw);
    else passed++;
  endtask

  task automatic test_basic();
    logic saw = 1'b0;
    expect_fetch(24'd0);
    expect_fetch(24'd3);
    instr_ready = 1'b1;
    halt        = 1'b0;
    tick();
    total++;
    if (busy !== 1'b1) $display("FAIL busy_f1: got %b expected 1", busy);
    else passed++;
    tick(); tick();
    total++;
    if (instr_valid !== 1'b0) $display("FAIL latency_early: valid=%b expected 0 at N+3", instr_valid);
    else passed++;
    tick();
    total++;
    if ({instr_valid, busy} !== 2'b10) $display("FAIL latency: valid,busy=%b expected 10 at N+4", {instr_valid, busy});
    else passed++;
    tick();
    total++;
    if (instr_valid !== 1'b0) $display("FAIL valid_drop: got %b expected 0 after handshake", instr_valid);
    else passed++;
    tick();
    halt = 1'b1;
    wait_valid(8, "basic_second");
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      saw |= (mem_read | busy | instr_valid);
    end
    total++;
    if (saw !== 1'b0) $display("FAIL halt_after_handoff: activity=%b expected 0", saw);
    else passed++;
  endtask

  task automatic test_stall();
    instr_ready = 1'b0;
    expect_fetch(24'd6);
    halt = 1'b0;
    tick();
    halt = 1'b1;
    wait_valid(8, "stall_fetch");
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({instr_valid, mem_read, instr_pc, instruction} !== {1'b1, 1'b0, 24'd6, 24'h112233})
        $display("FAIL stall_hold: v=%b rd=%b ipc=%h ins=%h expected v=1 rd=0 ipc=000006 ins=112233",
                 instr_valid, mem_read, instr_pc, instruction);
      else passed++;
    end
    instr_ready = 1'b1;
    tick();
    total++;
    if (instr_valid !== 1'b0) $display("FAIL stall_release: valid=%b expected 0", instr_valid);
    else passed++;
    expect_fetch(24'd9);
    halt = 1'b0;
    tick();
    halt = 1'b1;
    wait_valid(8, "stall_next");
    tick();
  endtask

  task automatic test_redirect();
    aq.push_back(24'd12);
    aq.push_back(24'd13);
    halt = 1'b0;
    tick();
    tick();
    redirect    = 1'b1;
    redirect_pc = 24'h10;
    expect_fetch(24'h10);
    tick();
    redirect = 1'b0;
    total++;
    if ({instr_valid, mem_read, busy} !== 3'b000)
      $display("FAIL redirect_flush: v,rd,busy=%b expected 000", {instr_valid, mem_read, busy});
    else passed++;
    tick();
    halt = 1'b1;
    wait_valid(8, "redirect_fetch");
    tick();
  endtask

  task automatic test_redirect_handshake();
    expect_fetch(24'h13);
    halt = 1'b0;
    tick();
    halt = 1'b1;
    wait_valid(8, "rh_fetch");
    redirect    = 1'b1;
    redirect_pc = 24'h20;
    tick();
    redirect = 1'b0;
    total++;
    if (instr_valid !== 1'b0) $display("FAIL rh_valid: got %b expected 0", instr_valid);
    else passed++;
    expect_fetch(24'h20);
    halt = 1'b0;
    tick();
    halt = 1'b1;
    wait_valid(8, "rh_target");
    tick();
  endtask

  task automatic test_fault();
    logic bad = 1'b0;
    halt        = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 24'd126;
    tick();
    redirect = 1'b0;
    tick();
    total++;
    if ({fetch_error, mem_read, instr_valid, busy} !== 4'b1000)
      $display("FAIL fault_126: err,rd,v,busy=%b expected 1000", {fetch_error, mem_read, instr_valid, busy});
    else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      bad |= (mem_read | instr_valid | ~fetch_error);
    end
    total++;
    if (bad !== 1'b0) $display("FAIL fault_hold: deviation=%b expected 0", bad);
    else passed++;
    redirect    = 1'b1;
    redirect_pc = 24'd0;
    expect_fetch(24'd0);
    tick();
    redirect = 1'b0;
    total++;
    if (fetch_error !== 1'b0) $display("FAIL fault_clear: err=%b expected 0", fetch_error);
    else passed++;
    tick();
    halt = 1'b1;
    wait_valid(8, "fault_resume");
    tick();
    redirect    = 1'b1;
    redirect_pc = 24'd125;
    tick();
    redirect = 1'b0;
    expect_fetch(24'd125);
    halt = 1'b0;
    tick();
    halt = 1'b1;
    wait_valid(8, "last_valid_pc");
    tick();
    halt = 1'b0;
    tick();
    total++;
    if ({fetch_error, mem_read} !== 2'b10) $display("FAIL fault_128: err,rd=%b expected 10", {fetch_error, mem_read});
    else passed++;
    redirect    = 1'b1;
    redirect_pc = 24'hFFFFFE;
    tick();
    redirect = 1'b0;
    tick();
    total++;
    if (fetch_error !== 1'b1) $display("FAIL fault_wrap: err=%b expected 1", fetch_error);
    else passed++;
    halt        = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 24'd0;
    tick();
    redirect = 1'b0;
  endtask

  task automatic test_halt();
    logic saw = 1'b0;
    expect_fetch(24'd0);
    halt = 1'b0;
    tick();
    halt = 1'b1;
    tick();
    total++;
    if (busy !== 1'b1) $display("FAIL halt_midfetch_busy: got %b expected 1", busy);
    else passed++;
    wait_valid(6, "halt_midfetch");
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      saw |= (mem_read | busy | instr_valid);
    end
    total++;
    if (saw !== 1'b0) $display("FAIL halt_stays_f0: activity=%b expected 0", saw);
    else passed++;
  endtask

  task automatic test_reset_midfetch();
    aq.push_back(24'd3);
    aq.push_back(24'd4);
    halt = 1'b0;
    tick();
    tick();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({mem_read, mem_addr, instruction, instr_pc, instr_valid, busy, fetch_error} !== '0)
      $display("FAIL async_reset: rd=%b addr=%h ins=%h ipc=%h v=%b busy=%b err=%b expected all 0",
               mem_read, mem_addr, instruction, instr_pc, instr_valid, busy, fetch_error);
    else passed++;
    expect_fetch(24'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    total++;
    if ({mem_read, busy} !== 2'b00) $display("FAIL reset_release: rd,busy=%b expected 00", {mem_read, busy});
    else passed++;
    tick();
    halt = 1'b1;
    wait_valid(8, "restart");
    tick();
  endtask

  initial begin : main
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
    mem[3] = 8'h0A; mem[4] = 8'h0B; mem[5] = 8'h0C;
    mem[6] = 8'h11; mem[7] = 8'h22; mem[8] = 8'h33;
    mem[16] = 8'hA1; mem[17] = 8'hA2; mem[18] = 8'hA3;
    rst_n       = 1'b0;
    halt        = 1'b1;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;

    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_redirect_handshake();
    test_fault();
    test_halt();
    test_reset_midfetch();

    repeat (3) tick();
    total++;
    if (aq.size() != 0) $display("FAIL addr_queue: %0d reads expected but not seen", aq.size());
    else passed++;
    total++;
    if (iq.size() != 0) $display("FAIL instr_queue: %0d hand-offs expected but not seen", iq.size());
    else passed++;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
